// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
// pipe_ctrl: central pipeline controller for the five-stage CPU.
// Merges IF/ID stall requests, MEM exceptions and multi-cycle MDU sequencing
// into a per-stage stall vector, a flush strobe and a redirect PC.
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf_stall_cnt, a free-running
// count of stalled cycles.
// Outputs are combinational from requests and registered state, so a request
// takes effect in the same cycle it is raised.
module pipe_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        mdu_start,
  input  logic        excp_req,
  input  logic [31:0] excp_vec,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mdu_busy,
  output logic        mdu_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  // Counter reload: the start cycle is itself a held cycle, so the counter
  // covers the remaining MDU_LAT-1 held cycles.
  localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       mdu_active;

  assign mdu_active = ((state == RUN) && mdu_start) ||
                      ((state == MDU_WAIT) && (cnt != 8'd0));

  // MDU sequencer; an exception aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else if (excp_req) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else if (state == RUN) begin
      if (mdu_start) begin
        state <= MDU_WAIT;
        cnt   <= LAT_M1;
      end
    end else begin
      if (cnt != 8'd0) cnt <= cnt - 8'd1;
      else             state <= RUN;
    end
  end

  // Request arbitration: exception > MDU > load-use > fetch; all quiet in reset.
  always_comb begin
    stall    = 6'b000000;
    flush    = 1'b0;
    new_pc   = 32'd0;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    if (!rst) begin
      if (excp_req) begin
        flush  = 1'b1;
        new_pc = excp_vec;
      end else if (mdu_active) begin
        stall    = 6'b001111;
        mdu_busy = 1'b1;
      end else begin
        // Only the final MDU_WAIT cycle (cnt == 0) can reach here.
        if (state == MDU_WAIT) mdu_done = 1'b1;
        if (stallreq_id)      stall = 6'b000111;
        else if (stallreq_if) stall = 6'b000011;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Stalled-cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  perf_stall_cnt <= 32'd0;
    else if (stall != 6'd0)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pipe_ctrl with MDU_LAT=4. Inputs change 1ns after the
// rising edge, outputs are checked 1ns later, well clear of the next edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        mdu_start = 1'b0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_vec = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mdu_busy;
  logic        mdu_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .mdu_start(mdu_start), .excp_req(excp_req), .excp_vec(excp_vec),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_if, input logic i_id, input logic i_ms,
                       input logic i_ex, input logic [31:0] i_vec);
    stallreq_if = i_if;
    stallreq_id = i_id;
    mdu_start   = i_ms;
    excp_req    = i_ex;
    excp_vec    = i_vec;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                            input logic [31:0] e_pc, input logic e_busy, input logic e_done);
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check({tag, ".new_pc"}, new_pc, e_pc);
    check({tag, ".busy"}, 32'(mdu_busy), 32'(e_busy));
    check({tag, ".done"}, 32'(mdu_done), 32'(e_done));
  endtask

  initial begin
    // Reset held with active requests: everything must stay quiet.
    #2;
    drive(1, 1, 1, 1, 32'h1234_5678);
    expect_out("rst_hold", 6'b000000, 0, 32'd0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("idle", 6'b000000, 0, 32'd0, 0, 0);
    end

    // Load-use beats fetch stall, then fetch alone.
    cyc(); drive(1, 1, 0, 0, 32'd0); expect_out("if_id", 6'b000111, 0, 32'd0, 0, 0);
    cyc(); drive(1, 0, 0, 0, 32'd0); expect_out("if_only", 6'b000011, 0, 32'd0, 0, 0);

    // MDU op: start cycle with a concurrent load-use (MDU wins), restart ignored.
    cyc(); drive(0, 1, 1, 0, 32'd0); expect_out("mdu_c0", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("mdu_c1", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 1, 0, 32'd0); expect_out("mdu_c2", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("mdu_c3", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); expect_out("mdu_done", 6'b000000, 0, 32'd0, 0, 1);
    cyc(); expect_out("mdu_after", 6'b000000, 0, 32'd0, 0, 0);

    // Exception in the middle of an MDU op aborts it.
    cyc(); drive(0, 0, 1, 0, 32'd0); expect_out("ex_c0", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("ex_c1", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 1, 32'hBFC0_0380); expect_out("ex_c2", 6'b000000, 1, 32'hBFC0_0380, 0, 0);
    // Back in RUN: a fresh start is accepted immediately.
    cyc(); drive(0, 0, 1, 0, 32'd0); expect_out("ex_restart", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("re_c1", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); expect_out("re_c2", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); expect_out("re_c3", 6'b001111, 0, 32'd0, 1, 0);
    // Done cycle releases the hold; the fetch request shows through.
    cyc(); drive(1, 0, 0, 0, 32'd0); expect_out("re_done_if", 6'b000011, 0, 32'd0, 0, 1);

    // Exception and MDU start together: MDU_WAIT must not be entered.
    cyc(); drive(0, 0, 1, 1, 32'h8000_0180); expect_out("ex_and_ms", 6'b000000, 1, 32'h8000_0180, 0, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("ex_and_ms_next", 6'b000000, 0, 32'd0, 0, 0);

    // Vector present without excp_req must not leak onto new_pc.
    cyc(); drive(0, 0, 0, 0, 32'hDEAD_BEEF); expect_out("vec_no_req", 6'b000000, 0, 32'd0, 0, 0);

    // Reset asserted mid-MDU: outputs drop immediately, then clean RUN afterwards.
    cyc(); drive(0, 0, 1, 0, 32'd0); expect_out("rmid_c0", 6'b001111, 0, 32'd0, 1, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("rmid_c1", 6'b001111, 0, 32'd0, 1, 0);
    #1;
    rst = 1'b1;
    stallreq_id = 1'b1;
    expect_out("rmid_async", 6'b000000, 0, 32'd0, 0, 0);
    cyc(); expect_out("rmid_held", 6'b000000, 0, 32'd0, 0, 0);
    cyc(); rst = 1'b0; expect_out("rmid_after", 6'b000111, 0, 32'd0, 0, 0);
    cyc(); drive(0, 0, 0, 0, 32'd0); expect_out("rmid_idle", 6'b000000, 0, 32'd0, 0, 0);

`ifdef PIPE_CTRL_PERF_EN
    // One MDU op (4 stalled cycles) plus 2 load-use cycles -> 6.
    cyc(); rst = 1'b1; #1;
    check("perf_rst", perf_stall_cnt, 32'd0);
    cyc(); rst = 1'b0;
    cyc(); drive(0, 0, 1, 0, 32'd0);
    cyc(); drive(0, 0, 0, 0, 32'd0);
    cyc();
    cyc();
    cyc(); drive(0, 1, 0, 0, 32'd0);
    cyc();
    cyc(); drive(0, 0, 0, 0, 32'd0); #1;
    check("perf_cnt", perf_stall_cnt, 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
